// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 SDF FFT stage.
// Holds the stage state encoding and width helpers.
package fft_pkg;

    typedef enum logic [1:0] {
        FILL,
        SUM,
        DIFF
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Buffer/butterfly width: one guard bit over the sample width.
    function automatic int buf_w(input int in_w);
        return in_w + 1;
    endfunction

endpackage

// File: rtl/fft_fit.sv
// Scale and narrow a butterfly result to the output width.
// FFT_SDF_SAT_EN selects saturation instead of wrap when narrowing.
module fft_fit
    import fft_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int SCALE = 0
) (
    input  logic signed [buf_w(IN_W)-1:0] v,
    output logic signed [OUT_W-1:0]       y
);

    localparam int W = buf_w(IN_W);

    logic signed [W-1:0] sh;

    assign sh = (SCALE != 0) ? (v >>> 1) : v;

    generate
        if (OUT_W >= W) begin : g_wide
            assign y = OUT_W'(sh);
        end else begin : g_narrow
`ifdef FFT_SDF_SAT_EN
            logic ovf;
            assign ovf = (sh[W-1:OUT_W-1] != {(W-OUT_W+1){sh[W-1]}});
            assign y = ovf ? {sh[W-1], {(OUT_W-1){~sh[W-1]}}}
                           : sh[OUT_W-1:0];
`else
            logic unused_hi;
            assign unused_hi = ^sh[W-1:OUT_W];
            assign y = sh[OUT_W-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/fft_r2_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback first stage, real input.
// Optional saturation of results via FFT_SDF_SAT_EN (see fft_fit).
module fft_r2_sdf_stage
    import fft_pkg::*;
#(
    parameter int N     = 32,
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int SCALE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sel,
    output logic [clog2(N/2)-1:0]     out_idx,
    output logic                      out_last
);

    localparam int HALF  = N / 2;
    localparam int AW    = clog2(HALF);
    localparam int BUF_W = buf_w(IN_W);
    localparam logic [AW-1:0] LAST = AW'(HALF - 1);

    state_t state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;

    logic signed [BUF_W-1:0] mem [HALF];
    logic signed [BUF_W-1:0] rd, xs, s, d, fit_in, wdata;
    logic signed [OUT_W-1:0] fit_out, data_nx;
    logic [AW-1:0] idx_nx;
    logic we, xfer, valid_nx, sel_nx, last_nx;

    assign in_ready = !rst && (state != DIFF);
    assign xfer     = in_valid && in_ready;
    assign rd       = mem[cnt];
    assign xs       = BUF_W'(in_data);
    assign s        = rd + xs;
    assign d        = rd - xs;
    assign fit_in   = (state == SUM) ? s : rd;

    fft_fit #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SCALE(SCALE)
    ) u_fit (
        .v(fit_in),
        .y(fit_out)
    );

    // Next-state, buffer write and next-output decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        we       = 1'b0;
        wdata    = xs;
        valid_nx = 1'b0;
        data_nx  = out_data;
        sel_nx   = out_sel;
        idx_nx   = out_idx;
        last_nx  = 1'b0;
        unique case (state)
            FILL: begin
                if (xfer) begin
                    we     = 1'b1;
                    cnt_nx = cnt + AW'(1);
                    if (cnt == LAST) state_nx = SUM;
                end
            end
            SUM: begin
                if (xfer) begin
                    we       = 1'b1;
                    wdata    = d;
                    valid_nx = 1'b1;
                    data_nx  = fit_out;
                    sel_nx   = 1'b0;
                    idx_nx   = cnt;
                    cnt_nx   = cnt + AW'(1);
                    if (cnt == LAST) state_nx = DIFF;
                end
            end
            DIFF: begin
                valid_nx = 1'b1;
                data_nx  = fit_out;
                sel_nx   = 1'b1;
                idx_nx   = cnt;
                cnt_nx   = cnt + AW'(1);
                if (cnt == LAST) begin
                    last_nx  = 1'b1;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // State, address counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= valid_nx;
            out_data  <= data_nx;
            out_sel   <= sel_nx;
            out_idx   <= idx_nx;
            out_last  <= last_nx;
        end
    end

    // Delay buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) mem[cnt] <= wdata;
    end

endmodule

// File: tb/tb_fft_r2_sdf_stage.sv
// Directed bench for fft_r2_sdf_stage (SCALE=1 and SCALE=0 instances).
// Expectations follow FFT_SDF_SAT_EN when it is defined.
module tb_fft_r2_sdf_stage;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic              v1, r1, ov1, os1, ol1;
  logic signed [7:0] d1, od1;
  logic [3:0]        oi1;
  logic              v0, r0, ov0, os0, ol0;
  logic signed [7:0] d0, od0;
  logic [3:0]        oi0;

  fft_r2_sdf_stage #(.N(32), .IN_W(8), .OUT_W(8), .SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .out_valid(ov1), .out_data(od1),
    .out_sel(os1), .out_idx(oi1), .out_last(ol1)
  );

  fft_r2_sdf_stage #(.N(32), .IN_W(8), .OUT_W(8), .SCALE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0),
    .in_data(d0), .out_valid(ov0), .out_data(od0),
    .out_sel(os0), .out_idx(oi0), .out_last(ol0)
  );

  typedef struct {
    logic signed [31:0] d;
    logic               sel;
    logic [3:0]         idx;
    logic               last;
    int                 cyc;
  } ev_t;

  ev_t q1[$];
  ev_t q0[$];
  int  rdy_low1 = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (ov1 === 1'b1) begin
      e.d = od1; e.sel = os1; e.idx = oi1;
      e.last = ol1; e.cyc = cyc;
      q1.push_back(e);
    end
    if (ov0 === 1'b1) begin
      e.d = od0; e.sel = os0; e.idx = oi0;
      e.last = ol0; e.cyc = cyc;
      q0.push_back(e);
    end
    if (rst === 1'b0 && r1 === 1'b0) rdy_low1++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v1 = 1'b0;
      v0 = 1'b0;
    end
  endtask

  task automatic send(input bit which, input int x[32], input int cnt,
                      input bit gap, output int stalls);
    int n;
    int guard;
    logic rdy;
    n = 0;
    guard = 0;
    stalls = 0;
    while (n < cnt && guard < 300) begin
      @(negedge clk);
      if (which) begin v1 = 1'b1; d1 = 8'(x[n]); end
      else begin v0 = 1'b1; d0 = 8'(x[n]); end
      rdy = which ? r1 : r0;
      if (rdy === 1'b1) begin
        n++;
        if (gap) begin
          @(negedge clk);
          v1 = 1'b0;
          v0 = 1'b0;
        end
      end else begin
        stalls++;
      end
      guard++;
    end
    chk("send_accepted", n, cnt);
  endtask

  task automatic wait_outs(input bit which, input int n);
    int g;
    g = 0;
    while ((which ? q1.size() : q0.size()) < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("outs_arrived",
        ((which ? q1.size() : q0.size()) >= n) ? 1 : 0, 1);
  endtask

  task automatic check_frame(input bit which, input int base,
                             input int fa[16], input int fb[16],
                             input bit gap);
    ev_t e, p;
    int k, ex, sp;
    for (int i = 0; i < 32; i++) begin
      e = which ? q1[base+i] : q0[base+i];
      k = i % 16;
      ex = (i < 16) ? fa[k] : fb[k];
      chk($sformatf("data[%0d]", i), e.d, ex);
      chk($sformatf("sel[%0d]", i), {31'd0, e.sel},
          (i >= 16) ? 1 : 0);
      chk($sformatf("idx[%0d]", i), {28'd0, e.idx}, k);
      chk($sformatf("last[%0d]", i), {31'd0, e.last},
          (i == 31) ? 1 : 0);
      if (i > 0) begin
        sp = (gap && i < 16) ? 2 : 1;
        chk($sformatf("spacing[%0d]", i), e.cyc - p.cyc, sp);
      end
      p = e;
    end
  endtask

  initial begin
    int ramp[32], rev[32], sat1[32], sat2[32];
    int fa_r[16], fb_r[16], fa_v[16], fb_v[16];
    int fa_s1[16], fb_s1[16], fa_s2[16], fb_s2[16];
    int st, st2, base, rl;

    for (int n = 0; n < 32; n++) begin
      ramp[n] = n;
      rev[n]  = 31 - n;
      sat1[n] = 127;
      sat2[n] = (n < 16) ? -128 : 127;
    end
    for (int k = 0; k < 16; k++) begin
      fa_r[k] = k + 8;
      fb_r[k] = -8;
      fa_v[k] = 23 - k;
      fb_v[k] = 8;
      fb_s1[k] = 0;
      fa_s2[k] = -1;
`ifdef FFT_SDF_SAT_EN
      fa_s1[k] = 127;
      fb_s2[k] = -128;
`else
      fa_s1[k] = -2;
      fb_s2[k] = 1;
`endif
    end

    rst = 1'b1;
    v1 = 1'b0; d1 = '0;
    v0 = 1'b0; d0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, ov1}, 0);
    chk("rst_data", od1, 0);
    chk("rst_sel", {31'd0, os1}, 0);
    chk("rst_idx", {28'd0, oi1}, 0);
    chk("rst_last", {31'd0, ol1}, 0);
    chk("rst_ready1", {31'd0, r1}, 0);
    chk("rst_ready0", {31'd0, r0}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, r1}, 1);

    base = q1.size();
    rl = rdy_low1;
    send(1'b1, ramp, 32, 1'b0, st);
    idle(1);
    wait_outs(1'b1, base + 32);
    idle(4);
    chk("ramp_count", q1.size() - base, 32);
    chk("ramp_ready_low", rdy_low1 - rl, 16);
    check_frame(1'b1, base, fa_r, fb_r, 1'b0);

    base = q1.size();
    send(1'b1, ramp, 32, 1'b1, st);
    wait_outs(1'b1, base + 32);
    idle(4);
    chk("gap_count", q1.size() - base, 32);
    check_frame(1'b1, base, fa_r, fb_r, 1'b1);

    base = q1.size();
    send(1'b1, ramp, 32, 1'b0, st);
    send(1'b1, rev, 32, 1'b0, st2);
    idle(1);
    wait_outs(1'b1, base + 64);
    idle(4);
    chk("b2b_count", q1.size() - base, 64);
    chk("b2b_held", st2, 16);
    check_frame(1'b1, base, fa_r, fb_r, 1'b0);
    check_frame(1'b1, base + 32, fa_v, fb_v, 1'b0);

    base = q0.size();
    send(1'b0, sat1, 32, 1'b0, st);
    send(1'b0, sat2, 32, 1'b0, st);
    idle(1);
    wait_outs(1'b0, base + 64);
    idle(4);
    chk("sat_count", q0.size() - base, 64);
    check_frame(1'b0, base, fa_s1, fb_s1, 1'b0);
    check_frame(1'b0, base + 32, fa_s2, fb_s2, 1'b0);

    send(1'b1, ramp, 21, 1'b0, st);
    @(negedge clk);
    v1 = 1'b0;
    chk("pre_rst_valid", {31'd0, ov1}, 1);
    chk("pre_rst_data", od1, 12);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, ov1}, 0);
    chk("mid_rst_data", od1, 0);
    chk("mid_rst_idx", {28'd0, oi1}, 0);
    chk("mid_rst_ready", {31'd0, r1}, 0);
    @(negedge clk);
    v1 = 1'b1;
    d1 = 8'sd99;
    @(negedge clk);
    chk("rst_blocks_ready", {31'd0, r1}, 0);
    v1 = 1'b0;
    rst = 1'b0;
    idle(1);
    base = q1.size();
    send(1'b1, ramp, 32, 1'b0, st);
    idle(1);
    wait_outs(1'b1, base + 32);
    idle(4);
    chk("post_rst_count", q1.size() - base, 32);
    check_frame(1'b1, base, fa_r, fb_r, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
